// File: rtl/enc_tx_scheduler.sv
// 8b/10b transmit scheduler: comma alignment, then source data or K28.5 idle fill, one word per clock.
// Drives an external combinational 5b/6b+3b/4b encoder; registers its code and tracks running disparity.
module enc_tx_scheduler #(
  parameter int         ALIGN_COUNT = 16,
  parameter logic [7:0] IDLE_BYTE   = 8'hBC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_k,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic       realign,
  output logic [4:0] enc_x,
  output logic [2:0] enc_y,
  output logic       enc_k,
  output logic       enc_disp,
  input  logic [9:0] enc_code,
  output logic [9:0] tx_code,
  output logic       tx_valid,
  output logic       link_up,
  output logic       err_k
);

  localparam int            CW       = (ALIGN_COUNT > 1) ? $clog2(ALIGN_COUNT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(ALIGN_COUNT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    ST_ALIGN = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_rd;
  logic          w_rd_nxt;
  logic [9:0]    r_tx_code;
  logic          r_tx_valid;
  logic          r_err_k;

  logic          w_ready;
  logic          w_accept;
  logic          w_k_legal;
  logic [7:0]    w_sel;
  logic          w_sel_k;
  logic          w_err_k;
  logic [3:0]    w_ones;

  // K28.0-K28.7 share EDCBA = 11100; the remaining legal K bytes are K23/27/29/30.7.
  function automatic logic k_legal(input logic [7:0] b);
    logic ok;
    ok = (b[4:0] == 5'h1C);
    case (b)
      8'hF7, 8'hFB, 8'hFD, 8'hFE: ok = 1'b1;
      default: ;
    endcase
    return ok;
  endfunction

  always_comb begin
    w_ready   = (r_state == ST_RUN) && !realign && !rst;
    w_accept  = s_valid && w_ready;
    w_k_legal = k_legal(s_data);
    w_sel     = IDLE_BYTE;
    w_sel_k   = 1'b1;
    w_err_k   = 1'b0;
    if (w_accept) begin
      // An illegal K byte is still consumed so the source cannot stall on it.
      if (s_k && !w_k_legal) begin
        w_err_k = 1'b1;
      end else begin
        w_sel   = s_data;
        w_sel_k = s_k;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_ALIGN: begin
        if (realign) begin
          w_cnt_nxt = CNT_LOAD;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      ST_RUN: begin
        if (realign) begin
          w_state_nxt = ST_ALIGN;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      default: begin
        w_state_nxt = ST_ALIGN;
        w_cnt_nxt   = CNT_LOAD;
      end
    endcase
  end

  always_comb begin
    w_ones = '0;
    for (int i = 0; i < 10; i++) begin
      w_ones = w_ones + {3'b000, enc_code[i]};
    end
    // A balanced word (five ones) leaves the running disparity where it was.
    if (w_ones > 4'd5) begin
      w_rd_nxt = 1'b1;
    end else if (w_ones < 4'd5) begin
      w_rd_nxt = 1'b0;
    end else begin
      w_rd_nxt = r_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_ALIGN;
      r_cnt      <= CNT_LOAD;
      r_rd       <= 1'b0;
      r_tx_code  <= 10'b0;
      r_tx_valid <= 1'b0;
      r_err_k    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rd       <= w_rd_nxt;
      r_tx_code  <= enc_code;
      r_tx_valid <= 1'b1;
      r_err_k    <= w_err_k;
    end
  end

  assign s_ready  = w_ready;
  assign enc_x    = w_sel[4:0];
  assign enc_y    = w_sel[7:5];
  assign enc_k    = w_sel_k;
  assign enc_disp = r_rd;
  assign tx_code  = r_tx_code;
  assign tx_valid = r_tx_valid;
  assign link_up  = (r_state == ST_RUN);
  assign err_k    = r_err_k;

endmodule
